// File: rtl/lfsr_16bit_checker.sv
// ============================================================================
// lfsr_16bit_checker
//
// Receive-side checker for the 16-bit LFSR sequence source.
// The source uses taps 15, 12, 5 and 1 with XNOR feedback and shifts once per
// enable. This checker works through three phases:
//   1. It fills a local copy of the register from the received bits.
//   2. It verifies a run of correct predictions and then declares lock.
//   3. It free-runs and counts every received bit that disagrees with its own
//      prediction.
// If errors become too dense inside a sliding window of valid bits, the
// checker drops lock and starts over from the fill phase.
//
// Ports:
//   clk_i      in   1         clock
//   rst_i      in   1         synchronous, active-high reset
//   valid_i    in   1         data_i carries a stream bit this cycle
//   data_i     in   1         received stream bit
//   clear_i    in   1         zero the error (and bit) counters, lock untouched
//   locked_o   out  1         checker is in the LOCKED phase
//   err_o      out  1         one-cycle pulse, one cycle after a mismatched bit
//   err_cnt_o  out  CntWidth  saturating count of errors seen while locked
//   bit_cnt_o  out  CntWidth  (optional) saturating count of bits checked
//                             while locked
//
// Optional feature macro: LFSR_16BIT_CHECKER_BITCNT_EN
//   When defined, the bit_cnt_o port and its counter are added. This gives
//   the bit-error-rate denominator. When undefined, both are absent and all
//   other behaviour is unchanged.
// ============================================================================
module lfsr_16bit_checker #(
    parameter int LockLen   = 16,
    parameter int ErrThresh = 4,
    parameter int WinLen    = 64,
    parameter int CntWidth  = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    input  logic                data_i,
    input  logic                clear_i,
    output logic                locked_o,
    output logic                err_o,
    output logic [CntWidth-1:0] err_cnt_o
`ifdef LFSR_16BIT_CHECKER_BITCNT_EN
    ,
    output logic [CntWidth-1:0] bit_cnt_o
`endif
);

    // The progress counter serves both the 16-bit fill and the lock run,
    // so it has to hold the larger of the two.
    localparam int ProgMax = (LockLen > 16) ? LockLen : 16;
    localparam int CW      = $clog2(ProgMax + 1);
    localparam int WW      = (WinLen > 1) ? $clog2(WinLen) : 1;
    localparam int EW      = $clog2(ErrThresh + 1);

    localparam logic [CW-1:0] FILL_LAST = CW'(15);
    localparam logic [CW-1:0] LOCK_CNT  = CW'(LockLen);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WinLen - 1);
    localparam logic [EW-1:0] THRESH    = EW'(ErrThresh);

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [15:0]         sr_q, sr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WW-1:0]       win_q, win_d;
    logic [EW-1:0]       werr_q, werr_d;
    logic                err_q, err_d;
    logic [CntWidth-1:0] err_cnt_q;

    logic          pred;
    logic          lockup;
    logic          mismatch;
    logic [CW-1:0] cnt_inc;
    logic          win_last;
    logic [EW-1:0] werr_win;

    // The next bit the source would emit, given the last 16 bits.
    assign pred   = ~(sr_q[15] ^ sr_q[12] ^ sr_q[5] ^ sr_q[1]);

    // All-ones is the XNOR lock-up state. A stuck-at-1 line would predict
    // itself forever, so a match from this state must never count toward lock.
    assign lockup = (sr_q == 16'hFFFF);

    assign mismatch = (data_i != pred);
    assign cnt_inc  = cnt_q + 1'b1;

    // The bit that wraps the window starts the new window's error count.
    // If that bit is itself an error, the new window opens at one error.
    assign win_last = (win_q == WIN_LAST);
    assign werr_win = (win_last ? '0 : werr_q) + EW'(mismatch);

    // Phase sequencing and register/window bookkeeping. Nothing moves
    // unless a valid bit arrives.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        werr_d  = werr_q;
        err_d   = 1'b0;
        if (valid_i) begin
            case (state_q)
                ST_FILL: begin
                    sr_d = {sr_q[14:0], data_i};
                    if (cnt_q == FILL_LAST) begin
                        state_d = ST_VERIFY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_VERIFY: begin
                    // Shift in received data so that the register resynchronises
                    // after any bad bit.
                    sr_d = {sr_q[14:0], data_i};
                    if (!mismatch && !lockup) begin
                        if (cnt_inc == LOCK_CNT) begin
                            state_d = ST_LOCKED;
                            cnt_d   = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Free-run on the prediction. A flipped input bit then
                    // costs exactly one error, not a burst of them.
                    sr_d   = {sr_q[14:0], pred};
                    err_d  = mismatch;
                    win_d  = win_q + 1'b1;
                    werr_d = werr_win;
                    if (werr_win == THRESH) begin
                        state_d = ST_FILL;
                        cnt_d   = '0;
                        sr_d    = '0;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_FILL;
            sr_q    <= '0;
            cnt_q   <= '0;
            win_q   <= '0;
            werr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            err_q   <= err_d;
        end
    end

    // Error counter. Clear wins over a same-cycle error, so that error is
    // dropped from the count even though err_o still pulses for it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else if (clear_i) begin
            err_cnt_q <= '0;
        end else if (valid_i && (state_q == ST_LOCKED) && mismatch &&
                     (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

`ifdef LFSR_16BIT_CHECKER_BITCNT_EN
    logic [CntWidth-1:0] bit_cnt_q;

    // Bits checked while locked. This counter survives loss of lock, so it
    // stays consistent with err_cnt_o for bit-error-rate reporting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt_q <= '0;
        end else if (clear_i) begin
            bit_cnt_q <= '0;
        end else if (valid_i && (state_q == ST_LOCKED) && (bit_cnt_q != '1)) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

    assign bit_cnt_o = bit_cnt_q;
`endif

    assign locked_o  = (state_q == ST_LOCKED);
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_lfsr_16bit_checker.sv
// ============================================================================
// tb_lfsr_16bit_checker
//
// Testbench for lfsr_16bit_checker. A reference source generates the LFSR
// stream, and selected bits can be inverted on the way to the checker.
//
// Each driven cycle steps a behavioural model of the checker. The model
// pushes its expected outputs into a queue. A separate monitor pops one
// entry after every clock edge that follows a driven cycle and compares it
// against the DUT.
//
// The model describes the checker by phase and counts:
//   - the lock run is counted as consecutive good predictions;
//   - the error-density window is identified by integer division of the
//     number of bits seen since lock.
//
// Directed checks against fixed values cover the lock timing and counter
// results of each scenario.
// ============================================================================
module tb_lfsr_16bit_checker;

    localparam int LOCK_LEN   = 16;
    localparam int ERR_THRESH = 4;
    localparam int WIN_LEN    = 64;
    localparam int CNT_W      = 32;

    localparam int M_FILL   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             valid;
    logic             data;
    logic             clear;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
`ifdef LFSR_16BIT_CHECKER_BITCNT_EN
    logic [CNT_W-1:0] bit_cnt;
`endif

    lfsr_16bit_checker #(
        .LockLen  (LOCK_LEN),
        .ErrThresh(ERR_THRESH),
        .WinLen   (WIN_LEN),
        .CntWidth (CNT_W)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  (valid),
        .data_i   (data),
        .clear_i  (clear),
        .locked_o (locked),
        .err_o    (err),
        .err_cnt_o(err_cnt)
`ifdef LFSR_16BIT_CHECKER_BITCNT_EN
        ,
        .bit_cnt_o(bit_cnt)
`endif
    );

    typedef struct {
        logic             locked;
        logic             err;
        logic [CNT_W-1:0] err_cnt;
        logic [CNT_W-1:0] bit_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;

    // Reference source state.
    logic [15:0] gen;

    // Behavioural model state.
    int               m_mode;
    logic [15:0]      m_hist;
    int               m_run;
    int               m_n;
    int               m_win_id;
    int               m_win_err;
    logic             m_err;
    logic [CNT_W-1:0] m_err_cnt;
    logic [CNT_W-1:0] m_bit_cnt;

    // Next bit of the source, given its last 16 output bits.
    function automatic logic lfsr_bit(input logic [15:0] s);
        return ~(s[15] ^ s[12] ^ s[5] ^ s[1]);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got,
                               input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h",
                     name, cycle, got, want);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input logic r, input logic v, input logic d,
                              input logic c);
        logic p;
        int   id;
        if (r) begin
            m_mode    = M_FILL;
            m_hist    = '0;
            m_run     = 0;
            m_n       = 0;
            m_win_id  = 0;
            m_win_err = 0;
            m_err     = 1'b0;
            m_err_cnt = '0;
            m_bit_cnt = '0;
            return;
        end
        m_err = 1'b0;
        if (v) begin
            p = lfsr_bit(m_hist);
            if (m_mode == M_FILL) begin
                m_hist = {m_hist[14:0], d};
                m_run++;
                if (m_run == 16) begin
                    m_mode = M_VERIFY;
                    m_run  = 0;
                end
            end else if (m_mode == M_VERIFY) begin
                if (d == p && m_hist != 16'hFFFF) m_run++;
                else m_run = 0;
                m_hist = {m_hist[14:0], d};
                if (m_run == LOCK_LEN) begin
                    m_mode    = M_LOCKED;
                    m_run     = 0;
                    m_n       = 0;
                    m_win_id  = 0;
                    m_win_err = 0;
                end
            end else begin
                m_hist = {m_hist[14:0], p};
                m_err  = (d != p);
                if (m_err && m_err_cnt != '1) m_err_cnt++;
                if (m_bit_cnt != '1) m_bit_cnt++;
                // Window k covers the locked bits k*WIN_LEN-1 .. (k+1)*WIN_LEN-2.
                id = (m_n + 1) / WIN_LEN;
                if (id != m_win_id) begin
                    m_win_id  = id;
                    m_win_err = 0;
                end
                if (m_err) m_win_err++;
                m_n++;
                if (m_win_err >= ERR_THRESH) begin
                    m_mode = M_FILL;
                    m_run  = 0;
                    m_hist = '0;
                end
            end
        end
        if (c) begin
            m_err_cnt = '0;
            m_bit_cnt = '0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic d,
                                 input logic c);
        exp_t e;
        @(negedge clk);
        rst   = r;
        valid = v;
        data  = d;
        clear = c;
        model_step(r, v, d, c);
        e.locked  = (m_mode == M_LOCKED);
        e.err     = m_err;
        e.err_cnt = m_err_cnt;
        e.bit_cnt = m_bit_cnt;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic flip, input logic c);
        logic fb;
        fb  = lfsr_bit(gen);
        gen = {gen[14:0], fb};
        applyStimulus(1'b0, 1'b1, fb ^ flip, c);
    endtask

    task automatic idle_cycle(input logic c);
        logic junk;
        junk = 1'($urandom);
        applyStimulus(1'b0, 1'b0, junk, c);
    endtask

    task automatic sample_now();
        @(posedge clk);
        #1;
    endtask

    // Feed clean bits until the next bit opens a fresh error window.
    task automatic align_window();
        for (int k = 0; k < WIN_LEN && ((m_n + 1) % WIN_LEN) != 0; k++)
            send_bit(1'b0, 1'b0);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_locked", locked, e.locked);
                checkOutput("sb_err", err, e.err);
                checkOutput("sb_err_cnt", err_cnt, e.err_cnt);
`ifdef LFSR_16BIT_CHECKER_BITCNT_EN
                checkOutput("sb_bit_cnt", bit_cnt, e.bit_cnt);
`endif
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        total++;
        bad++;
        $display("[TB] FAIL watchdog cycle=%0d got=running want=finished", cycle);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : stimulus
        int nv;
        int o1, o2, o3;
        int r;
        rst   = 1'b1;
        valid = 1'b0;
        data  = 1'b0;
        clear = 1'b0;
        gen   = '0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        sample_now();
        checkOutput("reset_locked", locked, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_err_cnt", err_cnt, 0);

        // Lock from a source seeded at zero: 16 fill + 16 verify bits
        for (int i = 1; i <= 32; i++) begin
            send_bit(1'b0, 1'b0);
            if (i == 31) begin
                sample_now();
                checkOutput("lock_early", locked, 0);
            end
            if (i == 32) begin
                sample_now();
                checkOutput("lock_at_32", locked, 1);
            end
        end
        for (int i = 0; i < 10000; i++) send_bit(1'b0, 1'b0);
        sample_now();
        checkOutput("clean_err_cnt", err_cnt, 0);
        checkOutput("clean_locked", locked, 1);

        // Single error on bit 100
        for (int i = 1; i <= 100; i++) send_bit(i == 100, 1'b0);
        sample_now();
        checkOutput("single_err_pulse", err, 1);
        checkOutput("single_err_cnt", err_cnt, 1);
        for (int i = 0; i < 50; i++) send_bit(1'b0, 1'b0);
        sample_now();
        checkOutput("single_still_locked", locked, 1);
        checkOutput("single_cnt_hold", err_cnt, 1);

        // Loss of lock: four errors inside one window, then relock
        idle_cycle(1'b1);
        align_window();
        for (int off = 0; off <= 30; off++)
            send_bit(off == 2 || off == 10 || off == 20 || off == 30, 1'b0);
        sample_now();
        checkOutput("lol_locked", locked, 0);
        checkOutput("lol_err_cnt", err_cnt, 4);
        for (int i = 1; i <= 32; i++) begin
            send_bit(1'b0, 1'b0);
            if (i == 31) begin
                sample_now();
                checkOutput("relock_early", locked, 0);
            end
            if (i == 32) begin
                sample_now();
                checkOutput("relock_at_32", locked, 1);
            end
        end

        // Sparse errors: three per window for 20 windows
        idle_cycle(1'b1);
        align_window();
        for (int w = 0; w < 20; w++) begin
            o1 = $urandom_range(0, 20);
            o2 = $urandom_range(21, 41);
            o3 = $urandom_range(42, 63);
            for (int off = 0; off < WIN_LEN; off++)
                send_bit(off == o1 || off == o2 || off == o3, 1'b0);
        end
        sample_now();
        checkOutput("sparse_err_cnt", err_cnt, 60);
        checkOutput("sparse_locked", locked, 1);

        // Lock-up pattern: constant ones never lock
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        sample_now();
        checkOutput("lockup_locked", locked, 0);
        checkOutput("lockup_err_cnt", err_cnt, 0);

        // Gaps: lock timing counted in valid bits only
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        gen = '0;
        nv  = 0;
        for (int k = 0; k < 4000 && nv < 32; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                nv++;
                send_bit(1'b0, 1'b0);
                if (nv == 31) begin
                    sample_now();
                    checkOutput("gap_lock_early", locked, 0);
                end
                if (nv == 32) begin
                    sample_now();
                    checkOutput("gap_lock_at_32", locked, 1);
                end
            end else begin
                idle_cycle(1'b0);
            end
        end
        checkOutput("gap_valid_count", nv, 32);

        // Clear on the same cycle as an error bit
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1) send_bit(1'b0, 1'b0);
            else idle_cycle(1'b0);
        end
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) idle_cycle(1'b0);
        send_bit(1'b1, 1'b1);
        sample_now();
        checkOutput("clear_err_pulse", err, 1);
        checkOutput("clear_err_cnt", err_cnt, 0);

        // Random soak with gaps, sporadic errors and clears
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50) idle_cycle($urandom_range(0, 39) == 0);
            else send_bit($urandom_range(0, 63) == 0, $urandom_range(0, 39) == 0);
        end

        // Reset mid-operation from LOCKED
        for (int i = 0; i < 40; i++) send_bit(1'b0, 1'b0);
        sample_now();
        checkOutput("pre_reset_locked", locked, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        sample_now();
        checkOutput("mid_reset_locked", locked, 0);
        checkOutput("mid_reset_err_cnt", err_cnt, 0);

        idle_cycle(1'b0);
        idle_cycle(1'b0);
        sample_now();
        #1;
        checkOutput("queue_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
